// File: rtl/accumulator_cpu_if.sv
// rtl/accumulator_cpu_if.sv - bootload and debug port bundle for accumulator_cpu
interface accumulator_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              boot_en;
  logic              boot_we;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output boot_en, boot_we, boot_addr, boot_data, dbg_addr,
    input  dbg_data
  );

  modport slave (
    input  boot_en, boot_we, boot_addr, boot_data, dbg_addr,
    output dbg_data
  );
endinterface

// File: rtl/accumulator_cpu.sv
// rtl/accumulator_cpu.sv - parametrised accumulator CPU with on-chip RAM, bootload port and step enable
module accumulator_cpu #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int OPC_W    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  accumulator_cpu_if.slave  bus,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              flag_c,
  output logic              flag_z,
  output logic [1:0]        state,
  output logic              halted
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } stateT;

  stateT             curState;
  stateT             nextState;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mbr;
  logic [CNT_W-1:0]  stepCnt;
  logic              step;
  logic              holdAll;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              staWrite;

  assign holdAll  = !reset || bus.boot_en;
  assign step     = (stepCnt == CNT_W'(STEP_DIV - 1));
  assign opcode   = ir[DATA_W-1 -: OPC_W];
  assign operand  = ir[ADDR_W-1:0];
  assign sum      = {1'b0, acc} + {1'b0, mbr};
  // The extra top bit of the difference is the borrow: set exactly when acc < mbr.
  assign diff     = {1'b0, acc} - {1'b0, mbr};
  assign staWrite = !holdAll && step && (curState == EXEC) && (opcode == OP_STA);

  assign state        = curState;
  assign halted       = (curState == HALT);
  assign bus.dbg_data = mem[bus.dbg_addr];

  always_ff @(posedge clk) begin
    if (holdAll || step) stepCnt <= '0;
    else                 stepCnt <= stepCnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (holdAll)   curState <= FETCH;
    else if (step) curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    case (curState)
      FETCH:   nextState = DECODE;
      DECODE:  nextState = (opcode == OP_HLT) ? HALT : EXEC;
      EXEC:    nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (holdAll) begin
      acc    <= '0;
      pc     <= '0;
      ir     <= '0;
      mbr    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (step) begin
      case (curState)
        FETCH: begin
          ir <= mem[pc];
          pc <= pc + ADDR_W'(1);
        end
        DECODE: mbr <= mem[operand];
        EXEC: begin
          case (opcode)
            OP_LDA: begin
              acc    <= mbr;
              flag_z <= (mbr == '0);
            end
            OP_ADD: begin
              acc    <= sum[DATA_W-1:0];
              flag_c <= sum[DATA_W];
              flag_z <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              acc    <= diff[DATA_W-1:0];
              flag_c <= diff[DATA_W];
              flag_z <= (diff[DATA_W-1:0] == '0);
            end
            OP_JMP: pc <= operand;
            OP_JZ:  if (flag_z) pc <= operand;
            OP_JC:  if (flag_c) pc <= operand;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Boot writes bypass the step enable; an STA is dropped whenever boot_en is high.
  always_ff @(posedge clk) begin
    if (bus.boot_en && bus.boot_we) mem[bus.boot_addr] <= bus.boot_data;
    else if (staWrite)              mem[operand] <= acc;
  end
endmodule

// File: tb/tb_accumulator_cpu.sv
// tb/tb_accumulator_cpu.sv - scoreboard bench for accumulator_cpu at STEP_DIV 1 and 4
`timescale 1ns/1ps
module tb_accumulator_cpu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accumulator_cpu_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();
  accumulator_cpu_if #(.DATA_W(8), .ADDR_W(5)) bus4 ();

  logic [7:0] acc1, acc4, ir1, ir4;
  logic [4:0] pc1, pc4;
  logic       c1, z1, c4, z4, h1, h4;
  logic [1:0] st1, st4;

  accumulator_cpu #(.DATA_W(8), .ADDR_W(5), .OPC_W(3), .STEP_DIV(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .acc(acc1), .pc(pc1), .ir(ir1),
    .flag_c(c1), .flag_z(z1), .state(st1), .halted(h1)
  );

  accumulator_cpu #(.DATA_W(8), .ADDR_W(5), .OPC_W(3), .STEP_DIV(4)) u4 (
    .clk(clk), .reset(reset), .bus(bus4), .acc(acc4), .pc(pc4), .ir(ir4),
    .flag_c(c4), .flag_z(z4), .state(st4), .halted(h4)
  );

  typedef enum int {
    K_ACC, K_PC, K_IR, K_C, K_Z, K_STATE, K_HALTED, K_MEM,
    K_HALTCYC, K_VIOL, K_P_ACC, K_P_PC, K_P_IR, K_P_C, K_P_Z, K_P_STATE
  } kindT;

  typedef struct {
    string       tag;
    kindT        kind;
    int          addr;
    logic [31:0] value;
  } expT;

  expT expQ[$];
  int  nCompared;
  int  nMismatched;

  logic [7:0] img [32];
  bit         imgValid [32];

  int         haltCyc;
  int         viol;
  logic [7:0] pAcc, pIr;
  logic [4:0] pPc;
  logic       pC, pZ;
  logic [1:0] pState;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input string tag, input kindT kind, input int addr, input logic [31:0] value);
    expT e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.value = value;
    expQ.push_back(e);
  endtask

  task automatic getObs(input int dut, input kindT k, input int addr, output logic [31:0] v);
    v = '0;
    case (k)
      K_ACC:     v = 32'(dut == 0 ? acc1 : acc4);
      K_PC:      v = 32'(dut == 0 ? pc1 : pc4);
      K_IR:      v = 32'(dut == 0 ? ir1 : ir4);
      K_C:       v = 32'(dut == 0 ? c1 : c4);
      K_Z:       v = 32'(dut == 0 ? z1 : z4);
      K_STATE:   v = 32'(dut == 0 ? st1 : st4);
      K_HALTED:  v = 32'(dut == 0 ? h1 : h4);
      K_MEM: begin
        @(negedge clk);
        if (dut == 0) bus1.dbg_addr = 5'(addr);
        else          bus4.dbg_addr = 5'(addr);
        #1;
        v = 32'(dut == 0 ? bus1.dbg_data : bus4.dbg_data);
      end
      K_HALTCYC: v = 32'(haltCyc);
      K_VIOL:    v = 32'(viol);
      K_P_ACC:   v = 32'(pAcc);
      K_P_PC:    v = 32'(pPc);
      K_P_IR:    v = 32'(pIr);
      K_P_C:     v = 32'(pC);
      K_P_Z:     v = 32'(pZ);
      K_P_STATE: v = 32'(pState);
      default:   v = '0;
    endcase
  endtask

  task automatic drain(input int dut);
    expT         e;
    logic [31:0] v;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      getObs(dut, e.kind, e.addr, v);
      checkVal(e.tag, v, e.value);
    end
  endtask

  task automatic setBus(input int dut, input logic en, input logic we, input int addr, input logic [7:0] data);
    if (dut == 0) begin
      bus1.boot_en = en; bus1.boot_we = we; bus1.boot_addr = 5'(addr); bus1.boot_data = data;
    end else begin
      bus4.boot_en = en; bus4.boot_we = we; bus4.boot_addr = 5'(addr); bus4.boot_data = data;
    end
  endtask

  task automatic clearImg();
    for (int a = 0; a < 32; a++) begin
      img[a] = 8'h00; imgValid[a] = 1'b0;
    end
  endtask

  task automatic setImg(input int a, input logic [7:0] d);
    img[a] = d; imgValid[a] = 1'b1;
  endtask

  task automatic loadBasic();
    clearImg();
    setImg(0, 8'h0A); setImg(1, 8'h4B); setImg(2, 8'h2C); setImg(3, 8'hE0);
    setImg(10, 8'h05); setImg(11, 8'h03);
  endtask

  task automatic bootImg(input int dut);
    @(negedge clk);
    setBus(dut, 1'b1, 1'b0, 0, 8'h00);
    for (int a = 0; a < 32; a++) begin
      if (imgValid[a]) begin
        @(negedge clk);
        setBus(dut, 1'b1, 1'b1, a, img[a]);
      end
    end
    @(negedge clk);
    setBus(dut, 1'b1, 1'b0, 0, 8'h00);
  endtask

  // Releases boot_en and counts clocks; state changes on a non-step edge are tallied for the divided core.
  task automatic runProg(input int dut, input int probeCyc, input int maxCyc, input bit stopOnHalt);
    logic [1:0] prev;
    logic [1:0] cur;
    logic       h;
    haltCyc = -1;
    viol    = 0;
    @(negedge clk);
    if (dut == 0) bus1.boot_en = 1'b0;
    else          bus4.boot_en = 1'b0;
    prev = 2'd0;
    for (int cyc = 1; cyc <= maxCyc; cyc++) begin
      @(posedge clk);
      #1;
      cur = (dut == 0) ? st1 : st4;
      h   = (dut == 0) ? h1 : h4;
      if (dut == 1 && cur != prev && (cyc % 4) != 0) viol++;
      prev = cur;
      if (cyc == probeCyc) begin
        pAcc   = (dut == 0) ? acc1 : acc4;
        pPc    = (dut == 0) ? pc1 : pc4;
        pIr    = (dut == 0) ? ir1 : ir4;
        pC     = (dut == 0) ? c1 : c4;
        pZ     = (dut == 0) ? z1 : z4;
        pState = cur;
      end
      if (h && haltCyc < 0) haltCyc = cyc;
      if (stopOnHalt && h) break;
    end
  endtask

  task automatic pushResetState(input string pfx);
    pushExp({pfx, "_acc"}, K_ACC, 0, 0);
    pushExp({pfx, "_pc"}, K_PC, 0, 0);
    pushExp({pfx, "_ir"}, K_IR, 0, 0);
    pushExp({pfx, "_c"}, K_C, 0, 0);
    pushExp({pfx, "_z"}, K_Z, 0, 0);
    pushExp({pfx, "_state"}, K_STATE, 0, 0);
    pushExp({pfx, "_halted"}, K_HALTED, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b0;
    setBus(0, 1'b1, 1'b0, 0, 8'h00);
    setBus(1, 1'b1, 1'b0, 0, 8'h00);
    bus1.dbg_addr = '0;
    bus4.dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    pushResetState("rst");
    drain(0);
    @(negedge clk);
    reset = 1'b1;

    loadBasic();
    bootImg(0);
    pushExp("basic_halt_cycles", K_HALTCYC, 0, 11);
    pushExp("basic_acc", K_ACC, 0, 8'h08);
    pushExp("basic_c", K_C, 0, 0);
    pushExp("basic_z", K_Z, 0, 0);
    pushExp("basic_pc", K_PC, 0, 4);
    pushExp("basic_mem12", K_MEM, 12, 8'h08);
    runProg(0, 0, 100, 1'b1);
    drain(0);

    // LDA FF, ADD 01, JC 16; at 16 JZ 24; at 24 HLT.
    clearImg();
    setImg(0, 8'h14); setImg(1, 8'h55); setImg(2, 8'hD0);
    setImg(16, 8'hB8); setImg(24, 8'hE0);
    setImg(20, 8'hFF); setImg(21, 8'h01);
    bootImg(0);
    pushExp("jc_taken_pc", K_P_PC, 0, 16);
    pushExp("addc_halt_cycles", K_HALTCYC, 0, 14);
    pushExp("addc_acc", K_ACC, 0, 8'h00);
    pushExp("addc_c", K_C, 0, 1);
    pushExp("addc_z", K_Z, 0, 1);
    pushExp("jz_taken_pc", K_PC, 0, 25);
    runProg(0, 9, 100, 1'b1);
    drain(0);

    // LDA 3, SUB 5, STA 22, LDA 5, SUB 5, HLT.
    clearImg();
    setImg(0, 8'h14); setImg(1, 8'h75); setImg(2, 8'h36);
    setImg(3, 8'h17); setImg(4, 8'h77); setImg(5, 8'hE0);
    setImg(20, 8'h03); setImg(21, 8'h05); setImg(23, 8'h05);
    bootImg(0);
    pushExp("sub_borrow_acc", K_P_ACC, 0, 8'hFE);
    pushExp("sub_borrow_c", K_P_C, 0, 1);
    pushExp("sub_borrow_z", K_P_Z, 0, 0);
    pushExp("sub_zero_acc", K_ACC, 0, 8'h00);
    pushExp("sub_zero_c", K_C, 0, 0);
    pushExp("sub_zero_z", K_Z, 0, 1);
    pushExp("sub_mem22", K_MEM, 22, 8'hFE);
    pushExp("sub_pc", K_PC, 0, 6);
    pushExp("sub_halt_cycles", K_HALTCYC, 0, 17);
    runProg(0, 6, 100, 1'b1);
    drain(0);

    loadBasic();
    bootImg(1);
    pushExp("div4_halt_cycles", K_HALTCYC, 0, 44);
    pushExp("div4_offstep_changes", K_VIOL, 0, 0);
    pushExp("div4_acc", K_ACC, 0, 8'h08);
    pushExp("div4_pc", K_PC, 0, 4);
    pushExp("div4_mem12", K_MEM, 12, 8'h08);
    runProg(1, 0, 300, 1'b1);
    drain(1);

    // Abort an STA 12 in its EXEC step by raising boot_en.
    clearImg();
    setImg(0, 8'h0A); setImg(1, 8'h2C); setImg(2, 8'hE0);
    setImg(10, 8'h33); setImg(12, 8'h77);
    bootImg(0);
    pushExp("abort_in_exec", K_P_STATE, 0, 2);
    pushExp("abort_ir_sta", K_P_IR, 0, 8'h2C);
    runProg(0, 5, 5, 1'b0);
    drain(0);
    @(negedge clk);
    setBus(0, 1'b1, 1'b0, 0, 8'h00);
    @(posedge clk);
    #1;
    pushExp("abort_pc", K_PC, 0, 0);
    pushExp("abort_acc", K_ACC, 0, 0);
    pushExp("abort_state", K_STATE, 0, 0);
    pushExp("abort_mem12_kept", K_MEM, 12, 8'h77);
    drain(0);
    loadBasic();
    bootImg(0);
    pushExp("rerun_halt_cycles", K_HALTCYC, 0, 11);
    pushExp("rerun_acc", K_ACC, 0, 8'h08);
    pushExp("rerun_mem12", K_MEM, 12, 8'h08);
    runProg(0, 0, 100, 1'b1);
    drain(0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    pushResetState("halt_rst");
    pushExp("halt_rst_mem12_kept", K_MEM, 12, 8'h08);
    drain(0);
    @(negedge clk);
    reset = 1'b1;
    setBus(0, 1'b1, 1'b0, 0, 8'h00);

    // JMP 31; at 31 LDA 10 so the next fetch wraps pc to 0.
    clearImg();
    setImg(0, 8'h9F); setImg(31, 8'h0A); setImg(10, 8'h5A);
    bootImg(0);
    pushExp("wrap_pc", K_P_PC, 0, 0);
    pushExp("wrap_ir", K_P_IR, 0, 8'h0A);
    pushExp("wrap_acc", K_ACC, 0, 8'h5A);
    runProg(0, 4, 6, 1'b0);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/accumulator_cpu.md
# accumulator_cpu

Parametrised successor to our 8-bit accumulator CPU. It has an on-chip word-addressed RAM, a bootload port, carry and zero flags, conditional jumps and a halt state. It runs from one clock, using an internal step enable instead of a derived slow clock. Instruction width, data width and RAM depth are generic, so the same core serves the 8-bit board build and wider lab variants.

## Interface
- DATA_W, 8, data, accumulator and instruction word width; must be ≥ OPC_W + ADDR_W.
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W words.
- OPC_W, 3, opcode field width; the opcode is the top OPC_W bits of the instruction and the operand address is the low ADDR_W bits.
- STEP_DIV, 1, system clocks per FSM step; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- boot_en  in  1  bootload mode: holds the CPU and opens the RAM write port.
- boot_we  in  1  bootload write strobe; ignored unless boot_en=1.
- boot_addr  in  ADDR_W  bootload write address.
- boot_data  in  DATA_W  bootload write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational read of RAM[dbg_addr].
- acc  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- ir  out  DATA_W  instruction register.
- flag_c, flag_z  out  1 each  carry/borrow flag and zero flag.
- state  out  2  FETCH=0, DECODE=1, EXEC=2, HALT=3.
- halted  out  1  high when state=HALT.

## Operation
- Opcodes: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 JMP, 5 JZ, 6 JC, 7 HLT. Unused opcode values (OPC_W>3) execute as no-ops.
- **FETCH:** ir<=RAM[pc]; pc<=pc+1 mod DEPTH; go to DECODE.
- **DECODE:** mbr<=RAM[ir operand]; go to EXEC, or go to HALT if the opcode is HLT.
- **EXEC:** always returns to FETCH.
  - LDA: acc<=mbr; Z updated, C unchanged.
  - STA: RAM[operand]<=acc; flags unchanged.
  - ADD: {C,acc}<=acc+mbr, computed at DATA_W+1 bits.
  - SUB: acc<=acc-mbr mod 2**DATA_W; C<=1 when acc<mbr (borrow).
  - ADD and SUB both set Z<=(result==0).
  - JMP: pc<=operand. JZ: pc<=operand if Z=1. JC: pc<=operand if C=1.
- **HALT:** stays in HALT until reset is asserted or boot_en=1.
- **RAM:** DEPTH×DATA_W registers with asynchronous read. Writes come from STA (EXEC step) or from boot_we while boot_en=1. Reset does not clear RAM.
- **Bootload:** while boot_en=1:
  - step counter, pc, acc, ir, mbr and flags are held at 0 and state is held at FETCH;
  - boot_we=1 writes boot_data to RAM[boot_addr] at each clock edge.
  - When boot_en falls, execution starts at address 0. Asserting boot_en mid-instruction aborts that instruction, and any STA in the same cycle is suppressed.
- **Step enable:** a counter runs 0..STEP_DIV-1, and step=1 when the count equals STEP_DIV-1 (always 1 when STEP_DIV=1). The FSM and architectural registers change only when step=1. Boot writes are not gated by step.

## Timing
- Reset (reset=0 at an edge): acc=0, pc=0, ir=0, mbr=0, flag_c=0, flag_z=0, state=FETCH, halted=0, step counter=0. Reset has priority over boot_en.
- Every instruction except HLT takes 3 steps (3·STEP_DIV clocks). HLT reaches HALT after 2 steps.
- Outputs are registered and reflect the state after each step edge. dbg_data follows dbg_addr in the same cycle, including a boot or STA write made at the previous edge.
- pc wraps from DEPTH-1 to 0 with no flag.
- A boot write and a debug read of the same address in one cycle return the old data; the new data is visible from the next cycle.

## Test plan
- **Basic program** (STEP_DIV=1). Boot mem[0..3]=0x0A,0x4B,0x2C,0xE0 and mem[10]=0x05, mem[11]=0x03; release boot_en. Required: RAM[12]=0x08, acc=0x08, C=0, Z=0; halted=1 exactly 11 clocks after release; pc=4.
- **ADD carry.** Run LDA of 0xFF, then ADD of 0x01. Required: acc=0x00, C=1, Z=1. Then JC 0x10 → pc=0x10; JZ is also taken.
- **SUB borrow.** acc=0x03, SUB of 0x05. Required: acc=0xFE, C=1, Z=0. Then acc=0x05, SUB of 0x05 → acc=0x00, C=0, Z=1.
- **Step divider** (STEP_DIV=4). Same program as the basic test. Required: state changes only every 4th clock; halted=1 exactly 44 clocks after release; same final RAM and acc.
- **Boot mid-run.** Assert boot_en while in EXEC of an STA to address 12. Required: RAM[12] unchanged; pc=0, acc=0, state=FETCH on the next edge; a fresh program runs correctly after release.
- **Reset and wrap.** Assert reset during HALT → all outputs return to reset values and RAM is retained. Place JMP 31 at address 0 and a non-jump instruction at address 31 (ADDR_W=5) → pc wraps to 0 after the fetch at 31.
